// File: rtl/pong_pkg.sv
// Shared types and helpers for the pong field engine.
package pong_pkg;

    // Top-level game flow. The encoding is visible on the game_state output.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } game_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    // Top-left x that centres an object of width sz in a field of width h_res.
    function automatic int center_x(input int h_res, input int sz);
        return (h_res - sz) / 2;
    endfunction

    // Top y that centres an object of height sz in a field of height v_res.
    function automatic int center_y(input int v_res, input int sz);
        return (v_res - sz) / 2;
    endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: moves PAD_STEP pixels per enabled frame tick, saturating at
// the top and bottom of the field.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int V_RES    = 480,
    parameter int PAD_H    = 64,
    parameter int PAD_STEP = 4,
    parameter int Y_W      = $clog2(V_RES)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick,
    input  logic           enable,
    input  logic [1:0]     ctrl,
    output logic [Y_W-1:0] pad_y
);

    localparam logic [Y_W:0]   STEP_W   = (Y_W+1)'(PAD_STEP);
    localparam logic [Y_W:0]   MAX_W    = (Y_W+1)'(V_RES - PAD_H);
    localparam logic [Y_W-1:0] STEP     = Y_W'(PAD_STEP);
    localparam logic [Y_W-1:0] MAX_Y    = Y_W'(V_RES - PAD_H);
    localparam logic [Y_W-1:0] CENTER_Y = Y_W'(center_y(V_RES, PAD_H));

    logic [Y_W:0]   pad_w;
    logic [Y_W-1:0] pad_y_d;

    assign pad_w = {1'b0, pad_y};

    // Saturating up/down move; 00 and 11 both hold.
    always_comb begin
        pad_y_d = pad_y;
        if (tick && enable) begin
            case (ctrl)
                2'b10:   pad_y_d = (pad_w <= STEP_W) ? '0 : pad_y - STEP;
                2'b01:   pad_y_d = ((pad_w + STEP_W) >= MAX_W) ? MAX_Y : pad_y + STEP;
                default: pad_y_d = pad_y;
            endcase
        end
    end

    // Paddle position register, recentred on reset.
    always_ff @(posedge clk) begin
        if (reset) pad_y <= CENTER_Y;
        else       pad_y <= pad_y_d;
    end

endmodule

// File: rtl/pong_field_engine.sv
// Per-frame game-state core: paddles, ball motion, collisions, scoring and
// the serve / win flow. All outputs are registered.
//
// state | meaning
// IDLE  | after reset, ball centred, waiting for start
// SERVE | ball centred, counting down frames before launch
// PLAY  | ball moves once per frame tick
// POINT | one cycle: bump the scorer, decide between next serve and game over
// OVER  | winner reached, everything frozen until start
module pong_field_engine
    import pong_pkg::*;
#(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int PAD_H       = 64,
    parameter int PAD_W       = 4,
    parameter int PAD_X_L     = 16,
    parameter int PAD_X_R     = 620,
    parameter int BALL_SZ     = 8,
    parameter int PAD_STEP    = 4,
    parameter int BALL_STEP   = 2,
    parameter int SCORE_W     = 3,
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 60,
    localparam int X_W        = $clog2(H_RES),
    localparam int Y_W        = $clog2(V_RES)
) (
    input  logic               s_axi_aclk,
    input  logic               s_axi_areset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic [1:0]         Left_pad_control,
    input  logic [1:0]         Right_pad_control,
    output logic [X_W-1:0]     ball_x,
    output logic [Y_W-1:0]     ball_y,
    output logic [Y_W-1:0]     left_pad_y,
    output logic [Y_W-1:0]     right_pad_y,
    output logic [SCORE_W-1:0] L_side_s,
    output logic [SCORE_W-1:0] R_side_s,
    output logic [2:0]         game_state,
    output logic               hit_pulse,
    output logic               point_pulse,
    output logic               game_over
);

    localparam int SC_W = (SERVE_DELAY > 0) ? $clog2(SERVE_DELAY + 1) : 1;
    localparam logic [SC_W-1:0] SERVE_INIT = SC_W'(SERVE_DELAY);

    localparam logic [X_W-1:0] CX     = X_W'(center_x(H_RES, BALL_SZ));
    localparam logic [Y_W-1:0] CY     = Y_W'(center_y(V_RES, BALL_SZ));
    localparam logic [X_W-1:0] X_STEP = X_W'(BALL_STEP);
    localparam logic [Y_W-1:0] Y_STEP = Y_W'(BALL_STEP);
    localparam logic [X_W-1:0] L_FACE = X_W'(PAD_X_L + PAD_W);
    localparam logic [X_W-1:0] R_SNAP = X_W'(PAD_X_R - BALL_SZ);
    localparam logic [Y_W-1:0] Y_BOT  = Y_W'(V_RES - BALL_SZ);

    // One bit wider than the coordinates so no sum in a compare can wrap.
    localparam logic [X_W:0] X_STEP_W = (X_W+1)'(BALL_STEP);
    localparam logic [X_W:0] X_SZ_W   = (X_W+1)'(BALL_SZ);
    localparam logic [X_W:0] L_FACE_W = (X_W+1)'(PAD_X_L + PAD_W);
    localparam logic [X_W:0] R_FACE_W = (X_W+1)'(PAD_X_R);
    localparam logic [X_W:0] H_RES_W  = (X_W+1)'(H_RES);
    localparam logic [Y_W:0] Y_STEP_W = (Y_W+1)'(BALL_STEP);
    localparam logic [Y_W:0] Y_SZ_W   = (Y_W+1)'(BALL_SZ);
    localparam logic [Y_W:0] Y_BOT_W  = (Y_W+1)'(V_RES - BALL_SZ);
    localparam logic [Y_W:0] PAD_H_W  = (Y_W+1)'(PAD_H);

    localparam logic [SCORE_W-1:0] S_MAX = '1;
    localparam logic [SCORE_W-1:0] S_WIN = SCORE_W'(WIN_SCORE);

    game_state_t        state_q, state_d;
    logic [SC_W-1:0]    serve_cnt_q, serve_cnt_d;
    logic [X_W-1:0]     ball_x_d;
    logic [Y_W-1:0]     ball_y_d;
    logic               dx_q, dx_d, dy_q, dy_d;
    logic               point_right_q, point_right_d;
    logic [SCORE_W-1:0] l_score_d, r_score_d;
    logic               hit_d, point_d;

    logic [X_W:0]       bx;
    logic [Y_W:0]       by, lpy, rpy;
    logic               ov_l, ov_r;
    logic [SCORE_W-1:0] scorer, score_inc;
    logic               pad_enable;

    assign bx  = {1'b0, ball_x};
    assign by  = {1'b0, ball_y};
    assign lpy = {1'b0, left_pad_y};
    assign rpy = {1'b0, right_pad_y};

    // Overlap uses the paddle position from before this tick.
    assign ov_l = ((by + Y_SZ_W) > lpy) && (by < (lpy + PAD_H_W));
    assign ov_r = ((by + Y_SZ_W) > rpy) && (by < (rpy + PAD_H_W));

    assign scorer    = point_right_q ? R_side_s : L_side_s;
    assign score_inc = (scorer == S_MAX) ? scorer : scorer + 1'b1;

    assign pad_enable = (state_q != ST_OVER);
    assign game_state = state_q;

    pong_paddle #(
        .V_RES(V_RES), .PAD_H(PAD_H), .PAD_STEP(PAD_STEP), .Y_W(Y_W)
    ) u_left_pad (
        .clk(s_axi_aclk), .reset(s_axi_areset), .tick(frame_tick),
        .enable(pad_enable), .ctrl(Left_pad_control), .pad_y(left_pad_y)
    );

    pong_paddle #(
        .V_RES(V_RES), .PAD_H(PAD_H), .PAD_STEP(PAD_STEP), .Y_W(Y_W)
    ) u_right_pad (
        .clk(s_axi_aclk), .reset(s_axi_areset), .tick(frame_tick),
        .enable(pad_enable), .ctrl(Right_pad_control), .pad_y(right_pad_y)
    );

    // Next-state, ball motion, collisions and scoring.
    always_comb begin
        state_d       = state_q;
        serve_cnt_d   = serve_cnt_q;
        ball_x_d      = ball_x;
        ball_y_d      = ball_y;
        dx_d          = dx_q;
        dy_d          = dy_q;
        point_right_d = point_right_q;
        l_score_d     = L_side_s;
        r_score_d     = R_side_s;
        hit_d         = 1'b0;
        point_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SERVE;
                    serve_cnt_d = SERVE_INIT;
                end
            end

            ST_SERVE: begin
                if (frame_tick) begin
                    if (serve_cnt_q == '0) state_d = ST_PLAY;
                    else                   serve_cnt_d = serve_cnt_q - 1'b1;
                end
            end

            ST_PLAY: begin
                if (frame_tick) begin
                    // Vertical motion with wall bounce.
                    if (dy_q == DIR_DOWN) begin
                        if ((by + Y_STEP_W) >= Y_BOT_W) begin
                            ball_y_d = Y_BOT;
                            dy_d     = DIR_UP;
                        end else begin
                            ball_y_d = ball_y + Y_STEP;
                        end
                    end else begin
                        if (by <= Y_STEP_W) begin
                            ball_y_d = '0;
                            dy_d     = DIR_DOWN;
                        end else begin
                            ball_y_d = ball_y - Y_STEP;
                        end
                    end

                    // Horizontal motion: paddle hit, miss, or plain step.
                    if (dx_q == DIR_LEFT) begin
                        if ((bx >= L_FACE_W) && ((bx - X_STEP_W) <= L_FACE_W) && ov_l) begin
                            ball_x_d = L_FACE;
                            dx_d     = DIR_RIGHT;
                            hit_d    = 1'b1;
                        end else if (bx < X_STEP_W) begin
                            point_right_d = 1'b1;
                            state_d       = ST_POINT;
                        end else begin
                            ball_x_d = ball_x - X_STEP;
                        end
                    end else begin
                        if (((bx + X_SZ_W) <= R_FACE_W) &&
                            ((bx + X_SZ_W + X_STEP_W) >= R_FACE_W) && ov_r) begin
                            ball_x_d = R_SNAP;
                            dx_d     = DIR_LEFT;
                            hit_d    = 1'b1;
                        end else if ((bx + X_SZ_W + X_STEP_W) > H_RES_W) begin
                            point_right_d = 1'b0;
                            state_d       = ST_POINT;
                        end else begin
                            ball_x_d = ball_x + X_STEP;
                        end
                    end
                end
            end

            ST_POINT: begin
                point_d = 1'b1;
                if (point_right_q) r_score_d = score_inc;
                else               l_score_d = score_inc;
                if (score_inc == S_WIN) begin
                    state_d = ST_OVER;
                end else begin
                    ball_x_d    = CX;
                    ball_y_d    = CY;
                    // Serve toward whoever just conceded.
                    dx_d        = point_right_q ? DIR_LEFT : DIR_RIGHT;
                    serve_cnt_d = SERVE_INIT;
                    state_d     = ST_SERVE;
                end
            end

            ST_OVER: begin
                if (start) begin
                    l_score_d   = '0;
                    r_score_d   = '0;
                    ball_x_d    = CX;
                    ball_y_d    = CY;
                    dx_d        = DIR_RIGHT;
                    dy_d        = DIR_DOWN;
                    serve_cnt_d = SERVE_INIT;
                    state_d     = ST_SERVE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset wins over every other input.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state_q       <= ST_IDLE;
            serve_cnt_q   <= '0;
            ball_x        <= CX;
            ball_y        <= CY;
            dx_q          <= DIR_RIGHT;
            dy_q          <= DIR_DOWN;
            point_right_q <= 1'b0;
            L_side_s      <= '0;
            R_side_s      <= '0;
            hit_pulse     <= 1'b0;
            point_pulse   <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            state_q       <= state_d;
            serve_cnt_q   <= serve_cnt_d;
            ball_x        <= ball_x_d;
            ball_y        <= ball_y_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
            point_right_q <= point_right_d;
            L_side_s      <= l_score_d;
            R_side_s      <= r_score_d;
            hit_pulse     <= hit_d;
            point_pulse   <= point_d;
            game_over     <= (state_d == ST_OVER);
        end
    end

endmodule

// File: tb/tb_pong_field_engine.sv
// Directed bench for pong_field_engine at default parameters. Expected
// trajectories are worked out by hand from the field geometry.
module tb_pong_field_engine;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       start;
    logic [1:0] left_ctrl;
    logic [1:0] right_ctrl;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [8:0] left_pad_y;
    logic [8:0] right_pad_y;
    logic [2:0] l_score;
    logic [2:0] r_score;
    logic [2:0] game_state;
    logic       hit_pulse;
    logic       point_pulse;
    logic       game_over;

    int n_checks = 0;
    int n_errors = 0;

    pong_field_engine dut (
        .s_axi_aclk       (clk),
        .s_axi_areset     (reset),
        .frame_tick       (frame_tick),
        .start            (start),
        .Left_pad_control (left_ctrl),
        .Right_pad_control(right_ctrl),
        .ball_x           (ball_x),
        .ball_y           (ball_y),
        .left_pad_y       (left_pad_y),
        .right_pad_y      (right_pad_y),
        .L_side_s         (l_score),
        .R_side_s         (r_score),
        .game_state       (game_state),
        .hit_pulse        (hit_pulse),
        .point_pulse      (point_pulse),
        .game_over        (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame tick; returns on the negedge after the updating posedge.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        start      = 1'b0;
        left_ctrl  = 2'b00;
        right_ctrl = 2'b00;
        repeat (3) @(negedge clk);

        // Reset values.
        check_eq("rst_state", 32'(game_state), 0);
        check_eq("rst_ball_x", 32'(ball_x), 316);
        check_eq("rst_ball_y", 32'(ball_y), 236);
        check_eq("rst_lpad", 32'(left_pad_y), 208);
        check_eq("rst_rpad", 32'(right_pad_y), 208);
        check_eq("rst_lscore", 32'(l_score), 0);
        check_eq("rst_rscore", 32'(r_score), 0);
        check_eq("rst_hit", 32'(hit_pulse), 0);
        check_eq("rst_point", 32'(point_pulse), 0);
        check_eq("rst_over", 32'(game_over), 0);
        reset = 1'b0;

        // Paddle saturation while IDLE.
        left_ctrl = 2'b10;
        ticks(51);
        check_eq("lpad_up_51", 32'(left_pad_y), 4);
        ticks(1);
        check_eq("lpad_up_52", 32'(left_pad_y), 0);
        ticks(8);
        check_eq("lpad_up_60", 32'(left_pad_y), 0);
        check_eq("idle_ball_x", 32'(ball_x), 316);
        check_eq("idle_rpad", 32'(right_pad_y), 208);
        left_ctrl = 2'b11;
        ticks(3);
        check_eq("lpad_hold11", 32'(left_pad_y), 0);
        left_ctrl = 2'b01;
        ticks(110);
        check_eq("lpad_down_sat", 32'(left_pad_y), 416);
        left_ctrl = 2'b00;

        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        check_eq("rst2_lpad", 32'(left_pad_y), 208);

        // Serve, wall bounce, right hit, left hit.
        right_ctrl = 2'b01;
        pulse_start();
        check_eq("start_serve", 32'(game_state), 1);
        left_ctrl = 2'b10;
        ticks(6);
        left_ctrl = 2'b00;
        check_eq("lpad_184", 32'(left_pad_y), 184);
        pulse_start();
        check_eq("start_ignored", 32'(game_state), 1);
        ticks(54);
        check_eq("serve_tick60", 32'(game_state), 1);
        ticks(1);
        check_eq("play_tick61", 32'(game_state), 2);
        ticks(1);
        check_eq("play1_x", 32'(ball_x), 318);
        check_eq("play1_y", 32'(ball_y), 238);
        check_eq("rpad_416", 32'(right_pad_y), 416);
        ticks(117);
        check_eq("bounce_y", 32'(ball_y), 472);
        check_eq("bounce_x", 32'(ball_x), 552);
        ticks(1);
        check_eq("bounce_y_next", 32'(ball_y), 470);
        ticks(28);
        check_eq("pre_rhit_x", 32'(ball_x), 610);
        ticks(1);
        check_eq("rhit_x", 32'(ball_x), 612);
        check_eq("rhit_y", 32'(ball_y), 412);
        check_eq("rhit_pulse", 32'(hit_pulse), 1);
        @(negedge clk);
        check_eq("rhit_pulse_end", 32'(hit_pulse), 0);
        ticks(295);
        check_eq("pre_lhit_x", 32'(ball_x), 22);
        check_eq("pre_lhit_y", 32'(ball_y), 178);
        ticks(1);
        check_eq("lhit_x", 32'(ball_x), 20);
        check_eq("lhit_y", 32'(ball_y), 180);
        check_eq("lhit_pulse", 32'(hit_pulse), 1);
        @(negedge clk);
        check_eq("lhit_pulse_end", 32'(hit_pulse), 0);
        ticks(1);
        check_eq("after_lhit_x", 32'(ball_x), 22);
        check_eq("midplay_state", 32'(game_state), 2);

        // Reset mid-play, with a coincident frame tick.
        @(negedge clk) begin reset = 1'b1; frame_tick = 1'b1; end
        @(negedge clk) begin reset = 1'b0; frame_tick = 1'b0; end
        check_eq("mid_rst_state", 32'(game_state), 0);
        check_eq("mid_rst_x", 32'(ball_x), 316);
        check_eq("mid_rst_y", 32'(ball_y), 236);
        check_eq("mid_rst_lpad", 32'(left_pad_y), 208);
        check_eq("mid_rst_rpad", 32'(right_pad_y), 208);

        // Left miss: right scores, then serve goes left.
        pulse_start();
        ticks(61);
        ticks(148);
        check_eq("e_rhit_x", 32'(ball_x), 612);
        ticks(306);
        check_eq("e_edge_x", 32'(ball_x), 0);
        check_eq("e_edge_state", 32'(game_state), 2);
        ticks(1);
        check_eq("e_point_state", 32'(game_state), 3);
        @(negedge clk);
        check_eq("e_serve_state", 32'(game_state), 1);
        check_eq("e_rscore", 32'(r_score), 1);
        check_eq("e_lscore", 32'(l_score), 0);
        check_eq("e_point_pulse", 32'(point_pulse), 1);
        check_eq("e_recentre_x", 32'(ball_x), 316);
        check_eq("e_recentre_y", 32'(ball_y), 236);
        @(negedge clk);
        check_eq("e_point_end", 32'(point_pulse), 0);
        ticks(61);
        check_eq("e_play_state", 32'(game_state), 2);
        ticks(1);
        check_eq("e_serve_left_x", 32'(ball_x), 314);
        check_eq("e_serve_left_y", 32'(ball_y), 238);

        // Six more left misses take the right side to the winning score.
        for (int r = 2; r <= 7; r++) begin
            ticks((r == 2) ? 158 : 220);
            @(negedge clk);
            check_eq($sformatf("rscore_%0d", r), 32'(r_score), 32'(r));
        end
        check_eq("over_state", 32'(game_state), 4);
        check_eq("over_flag", 32'(game_over), 1);
        check_eq("over_point_pulse", 32'(point_pulse), 1);
        check_eq("over_ball_x", 32'(ball_x), 0);
        check_eq("over_ball_y", 32'(ball_y), 82);

        // Frozen in OVER.
        right_ctrl = 2'b10;
        left_ctrl  = 2'b01;
        ticks(5);
        check_eq("over_rpad_frozen", 32'(right_pad_y), 416);
        check_eq("over_lpad_frozen", 32'(left_pad_y), 208);
        check_eq("over_rscore_hold", 32'(r_score), 7);
        check_eq("over_x_hold", 32'(ball_x), 0);
        check_eq("over_state_hold", 32'(game_state), 4);
        right_ctrl = 2'b00;
        left_ctrl  = 2'b00;

        // Restart from OVER.
        pulse_start();
        check_eq("restart_state", 32'(game_state), 1);
        check_eq("restart_rscore", 32'(r_score), 0);
        check_eq("restart_lscore", 32'(l_score), 0);
        check_eq("restart_x", 32'(ball_x), 316);
        check_eq("restart_y", 32'(ball_y), 236);
        check_eq("restart_over", 32'(game_over), 0);
        check_eq("restart_rpad", 32'(right_pad_y), 416);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
